adj_div_clock_gen: RTL
======================

Name: adj_div_clock_gen

Overview:
- Downstream stage of the period-measurement/adjust block: consumes its 8-bit adjusted divisor and generates a divided tick and a square wave from the system clock.
- A new divisor is buffered in a shadow register and applied only at a period boundary (or immediately when idle), so output periods never glitch.
- Feeds LED/7-seg display logic and the lab test points.

Parameters:
- WIDTH, 8, divisor/counter width; must match the adjust block's adjustedDiv width.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- divIn  in  WIDTH  divisor from upstream adjustedDiv
- divValid  in  1  one-cycle load strobe for divIn
- enable  in  1  run enable
- tick  out  1  one-cycle pulse, once per divided period
- sqOut  out  1  square wave, period = activeDiv cycles
- activeDiv  out  WIDTH  divisor currently in use
- loadAck  out  1  one-cycle pulse, cycle after a pending divisor is applied
- running  out  1  high in RUN state

Behaviour:
- Reset (rst=0, async): state=IDLE, cnt=0, activeDiv=0, pendDiv=0, pendFlag=0; tick=0, sqOut=0, loadAck=0, running=0.
- Shadow load: on an edge with divValid=1, pendDiv<=divIn and pendFlag<=1. Repeated strobes before apply: last value wins.
- FSM states: IDLE, RUN.
- IDLE:
  - cnt=0; outputs tick=0, sqOut=0, running=0.
  - If pendFlag=1: activeDiv<=pendDiv, pendFlag<=0, and loadAck pulses next cycle.
  - A divValid in IDLE is captured on edge k and applied on edge k+1.
  - Go to RUN on an edge where enable=1 and activeDiv!=0. If pendFlag=1 on that edge, check the value being applied instead of activeDiv.
- RUN:
  - cnt counts 0..N-1 (N=activeDiv) and wraps to 0.
  - On the wrap edge, tick<=1, so tick is high while cnt=0. Otherwise tick<=0.
  - First tick occurs N edges after entering RUN.
- Boundary apply: on the wrap edge, if pendFlag=1, activeDiv<=pendDiv, pendFlag<=0, and loadAck pulses next cycle.
- divValid coincident with the wrap edge: divIn applies directly at that boundary (bypass), with a single loadAck.
- Applied divisor 0: go to IDLE on the same boundary. tick still pulses for the completed period.
- sqOut (registered): high while cnt < ceil(N/2), low otherwise.
  - N=1: sqOut=1 constantly and tick=1 every cycle.
  - Odd N: high phase is one cycle longer.
- enable=0 in RUN: next edge goes to IDLE, cnt=0, sqOut=0, tick=0. The partial period is discarded and pendFlag is retained.
- running=1 exactly while state=RUN.
- Mid-operation reset: immediate asynchronous return to reset values. Any pending divisor is lost.
- Arithmetic: cnt is WIDTH bits; ceil(N/2) is computed as (N+1)>>1 in WIDTH+1 bits, so N=255 gives a threshold of 128 without overflow.

Optional Feature:
- Macro: ADJ_DIV_TICK_COUNT_EN.
- Defined: adds output tickCount [WIDTH-1:0].
  - Increments on each tick and saturates at 2^WIDTH-1.
  - Clears to 0 on reset and on every divisor apply.
- Not defined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset then idle: rst=0 for 3 cycles, enable=0 -> all outputs 0, activeDiv=0; divIn=8, divValid for 1 cycle -> activeDiv=8 two edges later, loadAck one pulse.
- Basic divide: activeDiv=8, enable=1 -> tick every 8 cycles (first 8 edges after RUN entry); sqOut 4 high / 4 low; running=1.
- Odd/extreme divisors: N=5 -> sqOut 3 high / 2 low. N=1 -> tick and sqOut stuck high. N=255 -> 128 high / 127 low, tick every 255 cycles.
- Glitch-free reload:
  - Running N=8, divValid with divIn=24 at cnt=3 -> current period completes at 8, then periods of 24; loadAck one cycle after that boundary.
  - Two strobes (10, then 12) within one period -> 12 applied.
  - Strobe coincident with the wrap edge -> new value applies at that boundary.
- Stop conditions:
  - enable dropped at cnt=5 of N=8 -> IDLE next edge, sqOut=0, no tick.
  - Loading 0 while running -> final tick, then IDLE.
  - rst asserted mid-period -> outputs 0 immediately, without a clock edge.
- ADJ_DIV_TICK_COUNT_EN: N=2 run for 600 cycles -> tickCount saturates at 255; load 4 -> tickCount=0 on apply.

Source files
------------

// File: rtl/adj_div_clock_gen.sv
// -----------------------------------------------------------------------------
// adj_div_clock_gen
//
// Purpose:
//   Divides the system clock by an adjustable divisor. It produces a one-cycle
//   tick per divided period and a square wave whose period is the active
//   divisor. A new divisor is held in a shadow register. It is applied only at
//   a period boundary while running, or on the next edge while idle, so output
//   periods never glitch.
//
// Ports:
//   clk        in   system clock, all state on rising edge
//   rst        in   asynchronous, active-low reset
//   divIn      in   [WIDTH-1:0] divisor from upstream adjustedDiv
//   divValid   in   one-cycle load strobe for divIn
//   enable     in   run enable
//   tick       out  one-cycle pulse, once per divided period
//   sqOut      out  square wave, high while cnt < ceil(N/2)
//   activeDiv  out  [WIDTH-1:0] divisor currently in use
//   loadAck    out  one-cycle pulse, the cycle after a divisor is applied
//   running    out  high while in RUN
//   tickCount  out  [WIDTH-1:0] saturating tick counter (optional, see below)
//
// Optional feature:
//   Define ADJ_DIV_TICK_COUNT_EN to add the tickCount output. It counts ticks,
//   saturates at all-ones, and clears on reset and on every divisor apply.
// -----------------------------------------------------------------------------
module adj_div_clock_gen #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] divIn,
    input  logic             divValid,
    input  logic             enable,
    output logic             tick,
    output logic             sqOut,
    output logic [WIDTH-1:0] activeDiv,
    output logic             loadAck,
`ifdef ADJ_DIV_TICK_COUNT_EN
    output logic             running,
    output logic [WIDTH-1:0] tickCount
`else
    output logic             running
`endif
);

    localparam int unsigned CW = WIDTH + 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] cnt, cnt_d;
    logic [WIDTH-1:0] pend_div, pend_div_d;
    logic             pend_flag, pend_flag_d;
    logic [WIDTH-1:0] active_d;
    logic [WIDTH-1:0] new_div;
    logic [CW-1:0]    cnt_inc;
    logic             tick_d, sq_d, ack_d, running_d;

    // High-phase length ceil(n/2), widened one bit so n = all-ones cannot overflow
    function automatic logic [CW-1:0] half_ceil(input logic [WIDTH-1:0] n);
        half_ceil = ({1'b0, n} + CW'(1)) >> 1;
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state, datapath and output decode
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        active_d    = activeDiv;
        pend_div_d  = pend_div;
        pend_flag_d = pend_flag;
        new_div     = activeDiv;
        cnt_inc     = {1'b0, cnt} + CW'(1);
        tick_d      = 1'b0;
        sq_d        = 1'b0;
        ack_d       = 1'b0;

        // Shadow capture; later strobes overwrite earlier ones
        if (divValid) begin
            pend_div_d  = divIn;
            pend_flag_d = 1'b1;
        end

        case (state)
            IDLE: begin
                cnt_d = '0;
                // Idle apply uses the value held before this edge's strobe
                if (pend_flag) begin
                    new_div  = pend_div;
                    active_d = pend_div;
                    ack_d    = 1'b1;
                    if (!divValid) begin
                        pend_flag_d = 1'b0;
                    end
                end
                // Start decision looks at the divisor in force after this edge
                if (enable && (new_div != '0)) begin
                    state_d = RUN;
                    sq_d    = 1'b1;
                end
            end

            RUN: begin
                if (!enable) begin
                    // Partial period is dropped; any pending divisor survives
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_inc == {1'b0, activeDiv}) begin
                    cnt_d  = '0;
                    tick_d = 1'b1;
                    // A strobe on the boundary edge bypasses the shadow register
                    if (divValid) begin
                        new_div     = divIn;
                        active_d    = divIn;
                        pend_flag_d = 1'b0;
                        ack_d       = 1'b1;
                    end else if (pend_flag) begin
                        new_div     = pend_div;
                        active_d    = pend_div;
                        pend_flag_d = 1'b0;
                        ack_d       = 1'b1;
                    end
                    if (new_div == '0) begin
                        state_d = IDLE;
                    end else begin
                        sq_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_inc[WIDTH-1:0];
                    sq_d  = (cnt_inc < half_ceil(activeDiv));
                end
            end
        endcase

        running_d = (state_d == RUN);
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            activeDiv <= '0;
            pend_div  <= '0;
            pend_flag <= 1'b0;
            tick      <= 1'b0;
            sqOut     <= 1'b0;
            loadAck   <= 1'b0;
            running   <= 1'b0;
        end else begin
            cnt       <= cnt_d;
            activeDiv <= active_d;
            pend_div  <= pend_div_d;
            pend_flag <= pend_flag_d;
            tick      <= tick_d;
            sqOut     <= sq_d;
            loadAck   <= ack_d;
            running   <= running_d;
        end
    end

`ifdef ADJ_DIV_TICK_COUNT_EN
    // Saturating tick counter; an apply on the same edge as a tick wins
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tickCount <= '0;
        end else if (ack_d) begin
            tickCount <= '0;
        end else if (tick_d && (tickCount != {WIDTH{1'b1}})) begin
            tickCount <= tickCount + WIDTH'(1);
        end
    end
`endif

endmodule
